// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU definitions: fetch FSM state encoding, the bubble
//                instruction, the default reset PC and the PC increment.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

   // Fetch FSM states
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,   // one cycle after reset, no request
      S_FETCH   = 2'd1,   // request outstanding, response wanted
      S_HOLD    = 2'd2,   // response buffered while decode is stalled
      S_DISCARD = 2'd3    // stale request outstanding after a redirect
   } fetchState_t;

   localparam logic [31:0] c_NopInstr = 32'h0000_0000;  // sll $0,$0,0
   localparam logic [31:0] c_ResetPc  = 32'h0000_0000;
   localparam logic [31:0] c_PcIncr   = 32'd4;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : Pipeline register carrying {PC+4, instruction, valid}.
//                Priority: rst > i_flush > i_load > hold (default).
//  Ports       : clk, rst          clock, synchronous active-high reset
//                i_load            capture i_pc/i_instr as a valid entry
//                i_flush           replace contents with a bubble
//                i_pc, i_instr     incoming entry
//                o_pc, o_instr,
//                o_valid           registered entry (valid=0 marks a bubble)
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_reg
   import cpu_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = c_NopInstr
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_flush,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instr,
   output logic [31:0] o_pc,
   output logic [31:0] o_instr,
   output logic        o_valid
);

   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_valid;

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_pc    <= 32'h0;
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_pc    <= i_pc;
         r_instr <= i_instr;
         r_valid <= 1'b1;
      end
   end

   assign o_pc    = r_pc;
   assign o_instr = r_instr;
   assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage. Owns the PC, the instruction-memory
//                request/ready handshake and the IF/ID pipeline register;
//                honours hazard stalls and MEM-stage branch redirects.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                stall               hold PC and IF/ID
//                pc_src,
//                branch_target       redirect + flush, target address
//                imem_req, imem_addr request to instruction memory
//                imem_ready,
//                imem_rdata          memory response
//                if_id_pc,
//                if_id_instruction,
//                if_id_valid         IF/ID register towards decode
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = c_ResetPc,
   parameter logic [31:0] NOP_INSTR = c_NopInstr
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        pc_src,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instruction,
   output logic        if_id_valid
);

   fetchState_t r_state;
   fetchState_t w_stateNext;
   logic [31:0] r_pc;
   logic [31:0] w_pcNext;
   logic [31:0] r_reqAddr;
   logic [31:0] w_reqAddrNext;
   logic [31:0] r_holdInstr;
   logic [31:0] r_holdPc;
   logic        w_holdLoad;
   logic        w_ifIdLoad;
   logic        w_ifIdFlush;
   logic [31:0] w_ifIdPcIn;
   logic [31:0] w_ifIdInstrIn;
   logic [31:0] w_reqAddrInc;

   assign w_reqAddrInc = r_reqAddr + c_PcIncr;   // wraps modulo 2^32
   assign imem_addr    = r_reqAddr;
   assign imem_req     = (r_state == S_FETCH) || (r_state == S_DISCARD);

   always_comb begin
      w_stateNext   = r_state;
      w_pcNext      = r_pc;
      w_reqAddrNext = r_reqAddr;
      w_holdLoad    = 1'b0;
      w_ifIdLoad    = 1'b0;
      w_ifIdFlush   = 1'b0;
      w_ifIdPcIn    = w_reqAddrInc;
      w_ifIdInstrIn = imem_rdata;

      case (r_state)
         S_IDLE: begin
            // A redirect here is folded straight into the first request.
            if (pc_src) begin
               w_pcNext      = branch_target;
               w_reqAddrNext = branch_target;
            end else begin
               w_reqAddrNext = r_pc;
            end
            w_stateNext = S_FETCH;
         end

         S_FETCH: begin
            if (pc_src) begin
               w_ifIdFlush = 1'b1;
               w_pcNext    = branch_target;
               if (imem_ready) begin
                  w_reqAddrNext = branch_target;
               end else begin
                  // Request cannot be withdrawn; drain it first.
                  w_stateNext = S_DISCARD;
               end
            end else if (imem_ready) begin
               w_pcNext = w_reqAddrInc;
               if (stall) begin
                  w_holdLoad  = 1'b1;
                  w_stateNext = S_HOLD;
               end else begin
                  w_ifIdLoad    = 1'b1;
                  w_reqAddrNext = w_reqAddrInc;
               end
            end else if (!stall) begin
               // Decode consumed the entry and nothing new arrived.
               w_ifIdFlush = 1'b1;
            end
         end

         S_HOLD: begin
            // hold_buf is only read in this state, so leaving it on a
            // redirect is all the invalidation it needs.
            if (pc_src) begin
               w_ifIdFlush   = 1'b1;
               w_pcNext      = branch_target;
               w_reqAddrNext = branch_target;
               w_stateNext   = S_FETCH;
            end else if (!stall) begin
               w_ifIdLoad    = 1'b1;
               w_ifIdPcIn    = r_holdPc;
               w_ifIdInstrIn = r_holdInstr;
               w_reqAddrNext = r_pc;
               w_stateNext   = S_FETCH;
            end
         end

         S_DISCARD: begin
            if (pc_src) begin
               w_ifIdFlush = 1'b1;
               w_pcNext    = branch_target;
            end
            // Stale response dropped; restart from the newest target.
            if (imem_ready) begin
               w_reqAddrNext = pc_src ? branch_target : r_pc;
               w_stateNext   = S_FETCH;
            end
         end

         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_pc        <= RESET_PC;
         r_reqAddr   <= RESET_PC;
         r_holdInstr <= 32'h0;
         r_holdPc    <= 32'h0;
      end else begin
         r_state   <= w_stateNext;
         r_pc      <= w_pcNext;
         r_reqAddr <= w_reqAddrNext;
         if (w_holdLoad) begin
            r_holdInstr <= imem_rdata;
            r_holdPc    <= w_reqAddrInc;
         end
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifIdReg (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_ifIdLoad),
      .i_flush (w_ifIdFlush),
      .i_pc    (w_ifIdPcIn),
      .i_instr (w_ifIdInstrIn),
      .o_pc    (if_id_pc),
      .o_instr (if_id_instruction),
      .o_valid (if_id_valid)
   );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Testbench for fetch_stage. A memory model answers requests
//                with programmable latency; the expected instruction stream
//                (sequential from the last reset/redirect target) is queued
//                and popped whenever decode consumes a valid IF/ID entry.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

   localparam logic [31:0] c_ResetPc  = 32'h0000_0000;
   localparam logic [31:0] c_NopInstr = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        pc_src;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instruction;
   logic        if_id_valid;

   always #5 clk = ~clk;

   fetch_stage #(
      .RESET_PC  (c_ResetPc),
      .NOP_INSTR (c_NopInstr)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .stall             (stall),
      .pc_src            (pc_src),
      .branch_target     (branch_target),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_ready        (imem_ready),
      .imem_rdata        (imem_rdata),
      .if_id_pc          (if_id_pc),
      .if_id_instruction (if_id_instruction),
      .if_id_valid       (if_id_valid)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        expQ[$];
   exp_t        r_popped;
   int          nChecks = 0;
   int          nFails  = 0;
   int          nPopped = 0;
   int          latMin  = 1;
   int          latMax  = 1;
   bit          memBusy = 1'b0;
   int          memCnt  = 0;
   logic [31:0] memAddr = 32'h0;
   bit          forceLate = 1'b0;

   // Address-tagged instruction contents (bijective in the address).
   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Program order restarts at every reset/redirect target.
   task automatic rebuild(input logic [31:0] start);
      logic [31:0] a;
      a = start;
      expQ.delete();
      repeat (512) begin
         expQ.push_back('{pc: a + 32'd4, instr: memf(a)});
         a = a + 32'd4;
      end
   endtask

   // One clock: drive inputs for the next edge, answer memory requests.
   task automatic cycle(input logic r, input logic s, input logic p, input logic [31:0] t);
      @(posedge clk);
      #2;
      rst           = r;
      stall         = s;
      pc_src        = p;
      branch_target = t;
      if (forceLate) begin
         memBusy    = 1'b0;
         imem_ready = 1'b1;
         imem_rdata = memf(32'h40);
      end else if (!imem_req) begin
         memBusy    = 1'b0;
         imem_ready = 1'($urandom_range(1, 0));
         imem_rdata = $urandom;
      end else begin
         if (!memBusy) begin
            memBusy = 1'b1;
            memCnt  = $urandom_range(latMax, latMin) - 1;
            memAddr = imem_addr;
         end else begin
            check32("imem_addr_stable", imem_addr, memAddr);
         end
         imem_ready = (memCnt == 0);
         imem_rdata = imem_ready ? memf(imem_addr) : $urandom;
         if (imem_ready) memBusy = 1'b0;
         else            memCnt--;
      end
      if (r)      rebuild(c_ResetPc);
      else if (p) rebuild(t);
   endtask

   // Monitor: an entry is consumed at an edge with no stall/redirect/reset.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && !stall && !pc_src && if_id_valid) begin
            if (expQ.size() == 0) begin
               nChecks++;
               nFails++;
               $display("FAIL sb_underflow: got pc %h with empty queue", if_id_pc);
            end else begin
               r_popped = expQ.pop_front();
               check32("sb_pc", if_id_pc, r_popped.pc);
               check32("sb_instr", if_id_instruction, r_popped.instr);
               nPopped++;
            end
         end
      end
   end

   initial begin
      logic [31:0] t;
      int          popBase;
      rst = 1'b1; stall = 1'b0; pc_src = 1'b0; branch_target = 32'h0;
      imem_ready = 1'b0; imem_rdata = 32'h0;
      rebuild(c_ResetPc);

      // Reset and 1-cycle sequential fetch
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
      check32("rst_req", 32'(imem_req), 32'd0);
      check32("rst_valid", 32'(if_id_valid), 32'd0);
      check32("rst_instr", if_id_instruction, c_NopInstr);
      check32("rst_pc", if_id_pc, 32'h0);
      cycle(0, 0, 0, 0);
      check32("idle_req", 32'(imem_req), 32'd1);
      check32("idle_addr", imem_addr, c_ResetPc);
      check32("idle_valid", 32'(if_id_valid), 32'd0);
      for (int k = 0; k < 3; k++) begin
         cycle(0, 0, 0, 0);
         check32("seq_valid", 32'(if_id_valid), 32'd1);
         check32("seq_pc", if_id_pc, 32'(4 * (k + 1)));
         check32("seq_instr", if_id_instruction, memf(32'(4 * k)));
      end

      // Stall while the 0x10 response arrives
      cycle(0, 1, 0, 0);
      check32("pre_stall_addr", imem_addr, 32'h10);
      cycle(0, 1, 0, 0);
      check32("hold_req", 32'(imem_req), 32'd0);
      check32("hold_pc", if_id_pc, 32'h10);
      cycle(0, 1, 0, 0);
      check32("hold_pc", if_id_pc, 32'h10);
      cycle(0, 0, 0, 0);
      check32("hold_req", 32'(imem_req), 32'd0);
      check32("hold_instr", if_id_instruction, memf(32'h0C));
      cycle(0, 0, 0, 0);
      check32("release_pc", if_id_pc, 32'h14);
      check32("release_instr", if_id_instruction, memf(32'h10));
      check32("release_addr", imem_addr, 32'h14);

      // Redirect while a 3-cycle request to 0x20 is outstanding
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      latMin = 3; latMax = 3;
      cycle(0, 0, 0, 0);
      check32("slow_addr", imem_addr, 32'h20);
      cycle(0, 0, 1, 32'h100);
      cycle(0, 0, 0, 0);
      check32("discard_req", 32'(imem_req), 32'd1);
      check32("discard_addr", imem_addr, 32'h20);
      check32("discard_valid", 32'(if_id_valid), 32'd0);
      latMin = 1; latMax = 1;
      cycle(0, 0, 0, 0);
      check32("redir_addr", imem_addr, 32'h100);
      check32("redir_valid", 32'(if_id_valid), 32'd0);
      cycle(0, 0, 0, 0);
      check32("redir_pc", if_id_pc, 32'h104);
      check32("redir_instr", if_id_instruction, memf(32'h100));

      // Redirect and stall together: redirect wins
      cycle(0, 1, 1, 32'h200);
      cycle(0, 0, 0, 0);
      check32("rs_valid", 32'(if_id_valid), 32'd0);
      check32("rs_instr", if_id_instruction, c_NopInstr);
      check32("rs_addr", imem_addr, 32'h200);
      cycle(0, 0, 0, 0);
      check32("rs_pc", if_id_pc, 32'h204);

      // Reset in the middle of a request to 0x40, then a late ready
      cycle(0, 0, 1, 32'h40);
      latMin = 3; latMax = 3;
      cycle(0, 0, 0, 0);
      check32("mid_addr", imem_addr, 32'h40);
      cycle(1, 0, 0, 0);
      forceLate = 1'b1;
      cycle(0, 0, 0, 0);
      forceLate = 1'b0;
      latMin = 1; latMax = 1;
      check32("mrst_req", 32'(imem_req), 32'd0);
      check32("mrst_valid", 32'(if_id_valid), 32'd0);
      check32("mrst_instr", if_id_instruction, c_NopInstr);
      cycle(0, 0, 0, 0);
      check32("mrst_addr", imem_addr, c_ResetPc);
      check32("mrst_valid2", 32'(if_id_valid), 32'd0);
      cycle(0, 0, 0, 0);
      check32("mrst_pc", if_id_pc, 32'h4);
      check32("mrst_instr2", if_id_instruction, memf(32'h0));

      // Address wrap at the top of memory
      cycle(0, 0, 1, 32'hFFFF_FFF8);
      cycle(0, 0, 0, 0);
      check32("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
      cycle(0, 0, 0, 0);
      check32("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
      cycle(0, 0, 0, 0);
      check32("wrap_pc", if_id_pc, 32'h0);
      check32("wrap_instr", if_id_instruction, memf(32'hFFFF_FFFC));
      check32("wrap_addr2", imem_addr, 32'h0);

      // Randomized traffic
      latMin = 1; latMax = 3;
      popBase = nPopped;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(3, 0) == 0)
            t = 32'hFFFF_FFF0 + 32'($urandom_range(3, 0) * 4);
         else
            t = 32'($urandom_range(255, 0) * 4);
         cycle(1'($urandom_range(99, 0) < 1), 1'($urandom_range(99, 0) < 25),
               1'($urandom_range(99, 0) < 5), t);
      end
      repeat (5) cycle(0, 0, 0, 0);
      nChecks++;
      if (nPopped - popBase < 200) begin
         nFails++;
         $display("FAIL progress: got %0d entries expected at least 200", nPopped - popBase);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
`default_nettype wire
